// File: rtl/pipe_stage_chain_if.sv
// Handshake bundle for pipe_stage_chain: upstream (in_*) and downstream (out_*) ends.
// A beat moves across an end only in a cycle where its valid and ready are both 1;
// valid never depends on ready, and a producer holds valid/data until the beat moves.
interface pipe_stage_chain_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // master: the environment around the chain (feeds in_*, consumes out_*)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // slave: the chain itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// Elastic DEPTH-stage register chain with valid/ready on both ends, sync flush and
// occupancy count. `define PIPE_BUBBLE_COLLAPSE_EN selects per-stage ready (bubble squeeze).
module pipe_stage_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  pipe_stage_chain_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [DEPTH-1:0]             dbg_valid
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  // ld[i]: stage i takes whatever sits in front of it (stage i-1, or the input for i=0)
  logic [DEPTH-1:0] ld;
  logic             in_fire;
  logic             out_fire;

`ifdef PIPE_BUBBLE_COLLAPSE_EN
  logic [DEPTH-1:0] rdy;

  // Ready ripples from the output back to the input; a bubble breaks the stall.
  always_comb begin
    logic r;
    rdy = '0;
    r = !valid_q[DEPTH-1] || bus.out_ready;
    rdy[DEPTH-1] = r;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      r = !valid_q[i] || r;
      rdy[i] = r;
    end
  end

  assign ld = rdy;
`else
  logic adv;

  // Whole chain moves together or not at all; bubbles keep their slots while stalled.
  assign adv = !valid_q[DEPTH-1] || bus.out_ready;
  assign ld  = {DEPTH{adv}};
`endif

  assign bus.in_ready  = !rst && (flush || ld[0]);
  assign bus.out_valid = valid_q[DEPTH-1];
  assign bus.out_data  = data_q[DEPTH-1];
  assign count         = count_q;
  assign dbg_valid     = valid_q;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end

    if (flush) begin
      // Data is left alone: nothing valid enters, and a beat taken this cycle is dropped.
      valid_d = '0;
    end else begin
      if (ld[0]) begin
        valid_d[0] = bus.in_valid;
        if (bus.in_valid) begin
          data_d[0] = bus.in_data;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (ld[i]) begin
          valid_d[i] = valid_q[i-1];
          if (valid_q[i-1]) begin
            data_d[i] = data_q[i-1];
          end
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      unique case ({in_fire, out_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule
